// File: rtl/instr_fetch_if.sv
// Fetch-unit handshake bundle: instruction bus request/response, backend redirect,
// and the decoder-facing instruction stream.
interface instr_fetch_if;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        ireq_ready;
   logic        iresp_valid;
   logic [31:0] iresp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        out_misalign;

   modport master (
      output ireq_valid, ireq_addr, out_valid, out_instr, out_pc, out_misalign,
      input  ireq_ready, iresp_valid, iresp_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  ireq_valid, ireq_addr, out_valid, out_instr, out_pc, out_misalign,
      output ireq_ready, iresp_valid, iresp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding bus request, a small circular instruction buffer,
// redirect flush with late-response drop, and a halt on misaligned fetch PCs.
module instr_fetch #(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master bus
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic        misalign;
   } entry_t;

   state_t         state;
   logic [63:0]    fetch_pc, req_pc;
   entry_t         fifo_q [BUF_DEPTH];
   logic [PW-1:0]  rd_ptr, wr_ptr;
   logic [CW-1:0]  count;
   logic           has_room, push, pop;
   entry_t         push_entry, head;

   assign has_room = count < CW'(BUF_DEPTH);
   assign head     = fifo_q[rd_ptr];

   assign bus.ireq_valid   = (state == REQ);
   assign bus.ireq_addr    = (state == REQ) ? fetch_pc : '0;
   assign bus.out_valid    = (count != '0) && !bus.redirect_valid;
   assign bus.out_instr    = head.instr;
   assign bus.out_pc       = head.pc;
   assign bus.out_misalign = head.misalign;

   assign pop = bus.out_valid && bus.out_ready;

   // A misaligned PC produces a single NOP-marked entry instead of a bus request.
   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      if (!bus.redirect_valid) begin
         if (state == IDLE && fetch_pc[1:0] != 2'b00 && has_room) begin
            push       = 1'b1;
            push_entry = '{instr: 32'h0000_0013, pc: fetch_pc, misalign: 1'b1};
         end else if (state == WAIT && bus.iresp_valid) begin
            push       = 1'b1;
            push_entry = '{instr: bus.iresp_data, pc: req_pc, misalign: 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) fifo_q[i] <= '0;
      end else if (bus.redirect_valid) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_pc <= bus.redirect_pc;
         // An accepted-but-unanswered request must have its response swallowed.
         case (state)
            REQ:     state <= bus.ireq_ready  ? DROP : IDLE;
            WAIT:    state <= bus.iresp_valid ? IDLE : DROP;
            DROP:    state <= bus.iresp_valid ? IDLE : DROP;
            default: state <= IDLE;
         endcase
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= push_entry;
            wr_ptr         <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         case (state)
            IDLE: if (has_room) state <= (fetch_pc[1:0] == 2'b00) ? REQ : HALT;
            REQ: if (bus.ireq_ready) begin
               req_pc   <= fetch_pc;
               fetch_pc <= fetch_pc + 64'd4;
               state    <= WAIT;
            end
            WAIT: if (bus.iresp_valid) state <= IDLE;
            DROP: if (bus.iresp_valid) state <= IDLE;
            default: state <= HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, basic fetch, buffer back-pressure,
// redirect/drop, misalign halt, PC wrap and asynchronous reset.
module tb_instr_fetch;
   logic clk;
   logic reset;
   int   n_cmp, n_err;
   int   req_cnt;
   logic pend;
   logic [63:0] pend_addr;

   instr_fetch_if bus ();

   instr_fetch dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return {a[15:0], 16'h0093};
   endfunction

   // Bus model: answers each accepted request exactly one cycle later.
   task automatic run_bus(input int n);
      logic        nxt;
      logic [63:0] nxt_addr;
      for (int i = 0; i < n; i++) begin
         bus.iresp_valid = pend;
         bus.iresp_data  = word_at(pend_addr);
         #1;
         nxt      = bus.ireq_valid && bus.ireq_ready;
         nxt_addr = bus.ireq_addr;
         if (nxt) req_cnt++;
         @(posedge clk);
         #1;
         pend      = nxt;
         pend_addr = nxt_addr;
      end
      bus.iresp_valid = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; req_cnt = 0; pend = 1'b0; pend_addr = '0;
      reset = 1'b0;
      bus.ireq_ready = 1'b0; bus.iresp_valid = 1'b0; bus.iresp_data = '0;
      bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;

      repeat (2) tick();
      chk("rst_ireq_valid", bus.ireq_valid, 0);
      chk("rst_ireq_addr", bus.ireq_addr, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_instr", bus.out_instr, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_out_misalign", bus.out_misalign, 0);

      // First fetch after reset release
      reset = 1'b1;
      tick();
      chk("first_req_valid", bus.ireq_valid, 1);
      chk("first_req_addr", bus.ireq_addr, 64'h8000_0000);
      bus.ireq_ready = 1'b1; bus.out_ready = 1'b1;
      tick();
      chk("wait_no_req", bus.ireq_valid, 0);
      bus.ireq_ready = 1'b0; bus.iresp_valid = 1'b1; bus.iresp_data = 32'h0000_0093;
      tick();
      bus.iresp_valid = 1'b0;
      chk("first_out_valid", bus.out_valid, 1);
      chk("first_out_pc", bus.out_pc, 64'h8000_0000);
      chk("first_out_instr", bus.out_instr, 32'h0000_0093);
      chk("first_out_misalign", bus.out_misalign, 0);
      tick();
      chk("second_req_addr", bus.ireq_addr, 64'h8000_0004);
      chk("popped_empty", bus.out_valid, 0);

      // Back-pressure: buffer of 2 admits exactly two requests
      bus.out_ready = 1'b0; bus.ireq_ready = 1'b1; req_cnt = 0; pend = 1'b0;
      run_bus(12);
      chk("bp_req_count", req_cnt, 2);
      chk("bp_req_stalled", bus.ireq_valid, 0);
      chk("bp_head_pc", bus.out_pc, 64'h8000_0004);
      chk("bp_head_instr", bus.out_instr, 32'h0004_0093);
      bus.out_ready = 1'b1; req_cnt = 0;
      run_bus(1);
      bus.out_ready = 1'b0;
      run_bus(10);
      chk("bp_one_pop_one_req", req_cnt, 1);
      chk("bp_head_pc2", bus.out_pc, 64'h8000_0008);
      chk("bp_head_instr2", bus.out_instr, 32'h0008_0093);

      // Redirect gates output, then redirect during WAIT drops the late response
      bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_2000;
      #1;
      chk("rdr_gates_out", bus.out_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      chk("flushed", bus.out_valid, 0);
      tick();
      chk("rdr_req_addr", bus.ireq_addr, 64'h8000_2000);
      tick();
      bus.ireq_ready = 1'b0;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_1000;
      tick();
      bus.redirect_valid = 1'b0;
      chk("drop_no_req", bus.ireq_valid, 0);
      bus.iresp_valid = 1'b1; bus.iresp_data = 32'hDEAD_BEEF;
      tick();
      bus.iresp_valid = 1'b0;
      chk("beef_dropped", bus.out_valid, 0);
      tick();
      chk("post_drop_valid", bus.ireq_valid, 1);
      chk("post_drop_addr", bus.ireq_addr, 64'h8000_1000);
      chk("beef_never_out", bus.out_valid, 0);

      // Redirect coinciding with the response: no DROP cycle
      bus.ireq_ready = 1'b1;
      tick();
      bus.ireq_ready = 1'b0;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_3000;
      bus.iresp_valid = 1'b1; bus.iresp_data = 32'h1111_1111;
      tick();
      bus.redirect_valid = 1'b0; bus.iresp_valid = 1'b0;
      chk("same_cyc_no_push", bus.out_valid, 0);
      tick();
      chk("same_cyc_req_valid", bus.ireq_valid, 1);
      chk("same_cyc_req_addr", bus.ireq_addr, 64'h8000_3000);

      // Misaligned redirect target: one marked NOP, then halt
      bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h8000_1002;
      tick();
      bus.redirect_valid = 1'b0;
      chk("mis_idle_empty", bus.out_valid, 0);
      tick();
      chk("mis_out_valid", bus.out_valid, 1);
      chk("mis_flag", bus.out_misalign, 1);
      chk("mis_instr", bus.out_instr, 32'h0000_0013);
      chk("mis_pc", bus.out_pc, 64'h8000_1002);
      chk("mis_no_req", bus.ireq_valid, 0);
      bus.out_ready = 1'b1; bus.ireq_ready = 1'b1;
      tick();
      repeat (3) tick();
      chk("halt_no_out", bus.out_valid, 0);
      chk("halt_no_req", bus.ireq_valid, 0);

      // PC wrap at the top of the address space
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      chk("wrap_req_addr", bus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      bus.ireq_ready = 1'b0; bus.iresp_valid = 1'b1; bus.iresp_data = 32'h0000_0055;
      tick();
      bus.iresp_valid = 1'b0;
      chk("wrap_out_pc", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_out_instr", bus.out_instr, 32'h0000_0055);
      tick();
      chk("wrap_next_valid", bus.ireq_valid, 1);
      chk("wrap_next_addr", bus.ireq_addr, 64'h0);

      // Asynchronous reset mid-WAIT
      bus.ireq_ready = 1'b1;
      tick();
      bus.ireq_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_ireq_valid", bus.ireq_valid, 0);
      chk("arst_ireq_addr", bus.ireq_addr, 0);
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_instr", bus.out_instr, 0);
      chk("arst_out_pc", bus.out_pc, 0);
      chk("arst_out_misalign", bus.out_misalign, 0);
      tick();
      bus.iresp_valid = 1'b1; bus.iresp_data = 32'h0000_0BAD;
      tick();
      reset = 1'b1;
      tick();
      bus.iresp_valid = 1'b0;
      chk("arst_rel_valid", bus.ireq_valid, 1);
      chk("arst_rel_addr", bus.ireq_addr, 64'h8000_0000);
      chk("arst_rel_no_out", bus.out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the instruction buffer depth in entries; legal values are 2 or 4.
REQ-003 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  is an asynchronous, active-low reset.
REQ-005 ireq_valid  out  1  is the fetch request to the instruction bus.
REQ-006 ireq_addr  out  64  is the fetch byte address.
REQ-007 ireq_ready  in  1  means the bus accepts the request this cycle.
REQ-008 iresp_valid  in  1  means response data is present this cycle.
REQ-009 iresp_data  in  32  is the returned instruction word.
REQ-010 redirect_valid  in  1  is a branch/jump/trap redirect from the backend.
REQ-011 redirect_pc  in  64  is the redirect target.
REQ-012 out_valid  out  1  means an instruction is offered to the decoder.
REQ-013 out_ready  in  1  means the decoder accepts it this cycle.
REQ-014 out_instr  out  32  is the instruction word.
REQ-015 out_pc  out  64  is the PC of out_instr.
REQ-016 out_misalign  out  1  means the fetch PC had pc[1:0] != 0; out_instr is 32'h0000_0013 in that case.

Function
REQ-017 States: IDLE, REQ, WAIT, DROP, HALT; at most one bus request is outstanding.
REQ-018 IDLE->REQ when (count + 0) < BUF_DEPTH and fetch_pc[1:0] == 0; otherwise the block stays in IDLE.
REQ-019 IDLE with fetch_pc[1:0] != 0 and count < BUF_DEPTH: the block pushes one entry {instr 32'h13, pc fetch_pc, misalign 1}, issues no bus request, and goes to HALT.
REQ-020 REQ: ireq_valid = 1 and ireq_addr = fetch_pc; on ireq_ready the block records req_pc = fetch_pc, sets fetch_pc += 4, and goes to WAIT.
REQ-021 WAIT: on iresp_valid the block pushes {iresp_data, req_pc, 0} and goes to IDLE; the buffer is guaranteed to have room.
REQ-022 Issue rule: REQ is entered only if count < BUF_DEPTH counting the in-flight slot, so a response never overflows the buffer.
REQ-023 Buffer: a circular FIFO with wrap-around pointers; push and pop in the same cycle are allowed at any fill level, and count is unchanged.
REQ-024 out_valid = (count != 0) && !redirect_valid; out_instr, out_pc and out_misalign come from the head entry; a pop occurs on out_valid && out_ready.
REQ-025 Latency: a response in cycle N is visible on out_valid in cycle N+1.
REQ-026 Redirect: the buffer is flushed (count = 0) and fetch_pc = redirect_pc at the next edge, regardless of state.
REQ-027 Redirect in IDLE, REQ without ireq_ready, or HALT: next state is IDLE; an unaccepted request is withdrawn, which the bus permits.
REQ-028 Redirect in REQ with ireq_ready, or in WAIT without iresp_valid: next state is DROP.
REQ-029 Redirect in WAIT with iresp_valid in the same cycle: the response is discarded and next state is IDLE.
REQ-030 DROP: ireq_valid = 0; the next iresp_valid is discarded and the block goes to IDLE; a redirect in DROP updates fetch_pc and the block stays in DROP unless iresp_valid is also present that cycle, in which case it goes to IDLE.
REQ-031 HALT leaves only on redirect.
REQ-032 iresp_valid in IDLE, REQ or HALT is ignored.
REQ-033 PC arithmetic is 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.

Reset
REQ-034 While reset = 0: state = IDLE, fetch_pc = RESET_PC, count = 0, pointers = 0, ireq_valid = 0, out_valid = 0, and all other outputs are 0.
REQ-035 A reset asserted mid-transaction abandons any outstanding response; a response arriving after reset deasserts while in IDLE is ignored.
REQ-036 In the first cycle after reset deasserts, ireq_valid = 1 and ireq_addr = RESET_PC.

Verification
REQ-037 Reset release, ireq_ready = 1, response of 32'h0000_0093 one cycle later, out_ready = 1 -> out_valid with out_pc 0x8000_0000; the next request address is 0x8000_0004.
REQ-038 out_ready = 0 and BUF_DEPTH = 2, bus always ready -> exactly 2 requests issued, then ireq_valid stays 0; one pop -> exactly one new request.
REQ-039 Redirect to 0x8000_1000 while in WAIT, late response 0xDEADBEEF -> 0xDEADBEEF is never output, and the next request address is 0x8000_1000.
REQ-040 Redirect and iresp_valid in the same cycle -> the response is dropped, the next state is IDLE, and no DROP cycle occurs.
REQ-041 Redirect to 0x8000_1002 -> a single out_valid with out_misalign = 1, out_instr 0x13 and out_pc 0x8000_1002, no bus request, then idle until the next redirect.
REQ-042 Reset pulsed low during WAIT -> all outputs are 0 immediately (asynchronously), and after release the request address is RESET_PC.
